// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl
//   Acquisition sequencer for the ADS8861 capture path.
//   - Free-running sample timer drives convst (high for CONV_CYCLES of each
//     period, period = max(period, MIN_PERIOD), reloaded at every wrap).
//   - Samples returned by the reader (adc_valid/adc_data) are written into a
//     circular sample RAM during PRE / WAIT_TRIG / POST.
//   - Level/edge trigger (signed) with optional auto-trigger timeout;
//     the record holds pre_depth samples before the trigger sample and
//     2^ADDR_W - pre_depth - 1 after it.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   arm, stop           capture start / abort pulses (stop has priority)
//   period              sample period in clk cycles
//   trig_level/edge/auto trigger threshold, 0=rising 1=falling, auto mode
//   pre_depth           pre-trigger samples, captured at arm
//   convst              ADC conversion start
//   adc_valid, adc_data sample from the serial reader
//   wr_en/addr/data     sample RAM write port
//   busy, triggered, done, trig_addr  status to readout logic
module adc_acq_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int CONV_CYCLES  = 48,
  parameter int MIN_PERIOD   = 72,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              stop,
  input  logic [23:0]       period,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              trig_auto,
  input  logic [ADDR_W-1:0] pre_depth,
  output logic              convst,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] AUTO_MAX = TW'(AUTO_TIMEOUT);
  localparam logic [23:0]   MINP     = 24'(MIN_PERIOD);
  localparam logic [23:0]   CONVC    = 24'(CONV_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t              state, state_n;
  logic [23:0]         cnt, p_lat, p_eff;
  logic [ADDR_W-1:0]   ptr, scnt, pre_d, rem;
  logic [TW-1:0]       tcnt;
  logic [DATA_W-1:0]   prev;
  logic                prev_valid;
  logic                take, edge_hit, fire, arm_go;
  logic signed [DATA_W-1:0] cur_s, prv_s, lvl_s;

  assign p_eff = (period < MINP) ? MINP : period;
  // Samples remaining after the trigger sample: (2^ADDR_W - 1) - pre_d.
  assign rem   = ~pre_d;
  assign cur_s = adc_data;
  assign prv_s = prev;
  assign lvl_s = trig_level;

  assign busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign done = (state == S_DONE);

  always_comb begin
    take     = 1'b0;
    edge_hit = 1'b0;
    fire     = 1'b0;
    arm_go   = 1'b0;
    state_n  = state;
    take     = adc_valid && ((state == S_PRE) || (state == S_WAIT) || (state == S_POST));
    // First sample after arm has no predecessor and only seeds prev.
    if (prev_valid)
      edge_hit = trig_edge ? ((prv_s > lvl_s) && (cur_s <= lvl_s))
                           : ((prv_s < lvl_s) && (cur_s >= lvl_s));
    fire   = take && (state == S_WAIT) && (edge_hit || (trig_auto && (tcnt == AUTO_MAX)));
    arm_go = arm && !stop && ((state == S_IDLE) || (state == S_DONE));
    if (stop) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm) state_n = (pre_depth == '0) ? S_WAIT : S_PRE;
        S_PRE:  if (take && (scnt == pre_d - ADDR_W'(1))) state_n = S_WAIT;
        S_WAIT: if (fire) state_n = (rem == '0) ? S_DONE : S_POST;
        S_POST: if (take && (scnt == rem - ADDR_W'(1))) state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      p_lat      <= p_eff;
      convst     <= 1'b0;
      ptr        <= '0;
      scnt       <= '0;
      tcnt       <= '0;
      pre_d      <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      triggered  <= 1'b0;
      trig_addr  <= '0;
    end else begin
      state <= state_n;

      // sample timer: convst mirrors the count one cycle later
      if (cnt >= p_lat - 24'd1) begin
        cnt   <= '0;
        p_lat <= p_eff;
      end else begin
        cnt <= cnt + 24'd1;
      end
      convst <= (cnt < CONVC);

      wr_en <= take && !stop;
      if (take) begin
        wr_addr    <= ptr;
        wr_data    <= adc_data;
        ptr        <= ptr + ADDR_W'(1);
        prev       <= adc_data;
        prev_valid <= 1'b1;
      end

      // scnt counts samples within the current phase (PRE or POST)
      if (arm_go || (state_n != state)) scnt <= '0;
      else if (take)                    scnt <= scnt + ADDR_W'(1);

      if (arm_go)
        tcnt <= '0;
      else if (take && (state == S_WAIT) && !fire && (tcnt != AUTO_MAX))
        tcnt <= tcnt + TW'(1);

      if (arm_go) begin
        ptr        <= '0;
        prev_valid <= 1'b0;
        pre_d      <= pre_depth;
      end

      if (stop || arm_go) triggered <= 1'b0;
      else if (fire)      triggered <= 1'b1;
      if (fire) trig_addr <= ptr;
    end
  end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
module tb_adc_acq_ctrl;
  logic        clk = 1'b0;
  logic        rst, arm, stop, trig_edge, trig_auto, adc_valid;
  logic [23:0] period;
  logic [15:0] trig_level, adc_data;
  logic [9:0]  pre_depth;
  logic        convst, wr_en, busy, triggered, done;
  logic [9:0]  wr_addr, trig_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  adc_acq_ctrl #(.ADDR_W(10), .DATA_W(16), .CONV_CYCLES(48), .MIN_PERIOD(72),
                 .AUTO_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .period(period),
    .trig_level(trig_level), .trig_edge(trig_edge), .trig_auto(trig_auto),
    .pre_depth(pre_depth), .convst(convst), .adc_valid(adc_valid),
    .adc_data(adc_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .triggered(triggered), .done(done), .trig_addr(trig_addr));

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    logic        trg;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0;
  int         nwr = 0;
  logic [9:0] ptr_e = '0, last_addr = '0;
  logic       wrap_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // monitor: every RAM write must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%0d data=%0d required=none", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("wr_triggered", 32'(triggered), 32'(e.trg));
      end
      if (last_addr == 10'd1023 && wr_addr == 10'd0) wrap_seen = 1'b1;
      last_addr = wr_addr;
      nwr++;
    end
  end

  task automatic send(input logic [15:0] d, input logic exp_wr, input logic trg);
    exp_t e;
    @(negedge clk);
    adc_data  = d;
    adc_valid = 1'b1;
    if (exp_wr) begin
      e.addr = ptr_e; e.data = d; e.trg = trg;
      q.push_back(e);
      ptr_e = ptr_e + 10'd1;
    end
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic arm_cap(input logic [9:0] pd);
    @(negedge clk);
    pre_depth = pd;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    pre_depth = 10'd5;   // must be ignored until the next arm
    ptr_e = '0;
    nwr = 0;
    wrap_seen = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  // measure one full convst high run followed by its low run
  task automatic meas(output int hi, output int lo);
    int n;
    hi = -1; lo = -1;
    n = 0; while (convst !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    n = 0; while (convst !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) return;
    n = 0; while (convst === 1'b1 && n < 400) begin @(negedge clk); n++; end
    hi = n;
    n = 0; while (convst === 1'b0 && n < 400) begin @(negedge clk); n++; end
    lo = n;
  endtask

  task automatic flush_chk(input string name);
    repeat (4) @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int hi, lo;
    rst = 1'b1; arm = 0; stop = 0; period = 24'd100;
    trig_level = '0; trig_edge = 0; trig_auto = 0; pre_depth = '0;
    adc_valid = 0; adc_data = '0;
    repeat (5) @(negedge clk);
    chk("rst_convst", 32'(convst), 0);    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);  chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);        chk("rst_triggered", 32'(triggered), 0);
    chk("rst_done", 32'(done), 0);        chk("rst_trig_addr", 32'(trig_addr), 0);
    rst = 1'b0;

    // sample timing
    meas(hi, lo);
    chk("convst_hi_p100", 32'(hi), 48); chk("convst_lo_p100", 32'(lo), 52);
    period = 24'd10;
    meas(hi, lo); meas(hi, lo);
    chk("convst_hi_p10", 32'(hi), 48);  chk("convst_lo_p10", 32'(lo), 24);
    period = 24'd100;

    // idle samples are ignored
    send(16'd77, 0, 0);

    // rising trigger, pre 256; crossing inside PRE must be ignored
    trig_edge = 0; trig_level = 16'd0; trig_auto = 0;
    arm_cap(10'd256);
    for (int i = 0; i < 256; i++) send((i < 128) ? 16'(-1000) : 16'(1000), 1, 0);
    chk("ramp_busy_wait", 32'(busy), 1);
    for (int k = 0; k < 100; k++) send(16'(-1000 + 10 * k), 1, 0);
    chk("ramp_not_trig", 32'(triggered), 0);
    send(16'd0, 1, 1);
    chk("ramp_triggered", 32'(triggered), 1);
    chk("ramp_trig_addr", 32'(trig_addr), 356);
    for (int j = 0; j < 767; j++) begin
      send(16'(10 + 10 * j), 1, 1);
      if (j == 300) begin
        @(negedge clk); arm = 1'b1; @(negedge clk); arm = 1'b0;
      end
    end
    chk("ramp_done", 32'(done), 1);
    chk("ramp_busy_end", 32'(busy), 0);
    send(16'd123, 0, 0);
    chk("ramp_nwr", 32'(nwr), 1124);
    flush_chk("ramp_queue_empty");

    // falling, auto mode, timeout 20: forced trigger on 21st WAIT sample
    trig_edge = 1; trig_level = 16'd500; trig_auto = 1;
    arm_cap(10'd4);
    for (int i = 0; i < 24; i++) send(16'd1000, 1, 0);
    chk("auto_not_trig", 32'(triggered), 0);
    send(16'd1000, 1, 1);
    chk("auto_triggered", 32'(triggered), 1);
    chk("auto_trig_addr", 32'(trig_addr), 24);
    for (int j = 0; j < 1019; j++) send(16'd1000, 1, 1);
    chk("auto_done", 32'(done), 1);
    chk("auto_nwr", 32'(nwr), 1044);
    flush_chk("auto_queue_empty");

    // no auto: waits forever, then stop
    trig_auto = 0;
    arm_cap(10'd4);
    for (int i = 0; i < 64; i++) send(16'd1000, 1, 0);
    chk("noauto_busy", 32'(busy), 1);
    chk("noauto_done", 32'(done), 0);
    chk("noauto_trig", 32'(triggered), 0);
    pulse_stop();
    chk("stop_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) send(16'd1000, 0, 0);
    flush_chk("stop_queue_empty");

    // pre_depth 0: sample 0 seeds prev, sample 1 triggers
    trig_edge = 0; trig_level = 16'd0;
    arm_cap(10'd0);
    chk("pd0_busy", 32'(busy), 1);
    send(16'(-100), 1, 0);
    chk("pd0_not_trig", 32'(triggered), 0);
    send(16'd100, 1, 1);
    chk("pd0_trig_addr", 32'(trig_addr), 1);
    for (int j = 0; j < 1023; j++) send(16'd200, 1, 1);
    chk("pd0_done", 32'(done), 1);
    chk("pd0_nwr", 32'(nwr), 1025);
    chk("pd0_last_addr", 32'(last_addr), 0);
    chk("pd0_wrap", 32'(wrap_seen), 1);
    flush_chk("pd0_queue_empty");

    // arm and stop together from DONE: stop wins
    @(negedge clk); arm = 1'b1; stop = 1'b1;
    @(negedge clk); arm = 1'b0; stop = 1'b0;
    chk("armstop_done", 32'(done), 0);
    chk("armstop_busy", 32'(busy), 0);
    chk("armstop_trig", 32'(triggered), 0);
    send(16'd5, 0, 0);
    flush_chk("armstop_queue_empty");

    // reset in the middle of POST
    arm_cap(10'd0);
    send(16'(-100), 1, 0);
    send(16'd100, 1, 1);
    for (int j = 0; j < 10; j++) send(16'd300, 1, 1);
    chk("midpost_busy", 32'(busy), 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mrst_convst", 32'(convst), 0);   chk("mrst_wr_en", 32'(wr_en), 0);
    chk("mrst_wr_addr", 32'(wr_addr), 0); chk("mrst_wr_data", 32'(wr_data), 0);
    chk("mrst_busy", 32'(busy), 0);       chk("mrst_triggered", 32'(triggered), 0);
    chk("mrst_done", 32'(done), 0);       chk("mrst_trig_addr", 32'(trig_addr), 0);
    rst = 1'b0;
    flush_chk("mrst_queue_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
